// File: rtl/mul_pipe_unit.sv
// Three-stage pipelined RV32M multiplier: partial products, carry-save
// reduction, parallel-prefix final add, with whole-pipe stall and flush.
module mul_pipe_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW   = 2 * WIDTH;
  localparam int NPP  = WIDTH + 1;
  localparam int LVLS = $clog2(PW);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  // Kogge-Stone adder, carry-in zero, carry-out dropped.
  function automatic logic [PW-1:0] prefix_add(input logic [PW-1:0] x,
                                               input logic [PW-1:0] y);
    logic [PW-1:0] p0, g, p, g_n, p_n;
    p0 = x ^ y;
    g  = x & y;
    p  = p0;
    for (int l = 0; l < LVLS; l++) begin
      g_n = g;
      p_n = p;
      for (int i = (1 << l); i < PW; i++) begin
        g_n[i] = g[i] | (p[i] & g[i - (1 << l)]);
        p_n[i] = p[i] & p[i - (1 << l)];
      end
      g = g_n;
      p = p_n;
    end
    return p0 ^ (g << 1);
  endfunction

  logic          stall;
  logic          a_sign, b_sign;
  logic [PW-1:0] a_wide;
  logic [PW-1:0] pp_c [NPP];

  logic             vld_p0, vld_p1, vld_p2;
  logic [1:0]       op_p0, op_p1;
  logic [TAG_W-1:0] tag_p0, tag_p1, tag_p2;
  logic [PW-1:0]    pp_p0 [NPP];
  logic [PW-1:0]    sum_c, carry_c, sum_p1, carry_p1;
  logic [PW-1:0]    full_c;
  logic [WIDTH-1:0] res_c, res_p2;

  assign stall      = vld_p2 & ~out_ready;
  assign in_ready   = ~stall;
  assign out_valid  = vld_p2;
  assign out_result = res_p2;
  assign out_tag    = tag_p2;

  // Partial products of the (WIDTH+1)-bit operands; the rs2 sign bit carries
  // negative weight, so its row is the negated, shifted multiplicand.
  always_comb begin
    a_sign = ((in_op == OP_MULH) || (in_op == OP_MULHSU)) & in_a[WIDTH-1];
    b_sign = (in_op == OP_MULH) & in_b[WIDTH-1];
    a_wide = {{WIDTH{a_sign}}, in_a};
    for (int i = 0; i < WIDTH; i++) begin
      pp_c[i] = in_b[i] ? (a_wide << i) : '0;
    end
    pp_c[WIDTH] = b_sign ? -(a_wide << WIDTH) : '0;
  end

  // ---- S1 -> S2: 3:2 reduction of the registered partial products ----
  always_comb begin
    logic [PW-1:0] t;
    t       = '0;
    sum_c   = pp_p0[0];
    carry_c = pp_p0[1];
    for (int i = 2; i < NPP; i++) begin
      t       = sum_c ^ carry_c ^ pp_p0[i];
      carry_c = ((sum_c & carry_c) | (sum_c & pp_p0[i]) | (carry_c & pp_p0[i])) << 1;
      sum_c   = t;
    end
  end

  // ---- S2 -> S3: final add and half select ----
  always_comb begin
    full_c = prefix_add(sum_p1, carry_p1);
    res_c  = (op_p1 == OP_MUL) ? full_c[WIDTH-1:0] : full_c[PW-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (!stall) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      op_p0    <= in_op;
      tag_p0   <= in_tag;
      pp_p0    <= pp_c;
      op_p1    <= op_p0;
      tag_p1   <= tag_p0;
      sum_p1   <= sum_c;
      carry_p1 <= carry_c;
    end
  end

  // Output only moves on a real result so it stays put across bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_p2 <= '0;
      tag_p2 <= '0;
    end else if (!stall && vld_p1) begin
      res_p2 <= res_c;
      tag_p2 <= tag_p1;
    end
  end

endmodule
